input_deserializer: RTL



---
 rtl/nn_pkg.sv | 22 ++
 rtl/deser_word_buffer.sv | 36 +++
 rtl/input_deserializer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the input deserializer and the layer modules.
// DESER_DOUBLE_BUFFER_EN adds the FULL_WAIT state used by the double-buffered build.
package nn_pkg;

  localparam int DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_FILL      = 2'd0,
`ifdef DESER_DOUBLE_BUFFER_EN
    ST_HOLD      = 2'd1,
    ST_FULL_WAIT = 2'd2
`else
    ST_HOLD      = 2'd1
`endif
  } deser_state_t;

  // Word k of a frame bus sits at [slot_msb(k, w) -: w].
  function automatic int slot_msb(input int k, input int w);
    return (k + 1) * w - 1;
  endfunction

endpackage

// File: rtl/deser_word_buffer.sv
// numWords x dataWidth register file with a single-slot write port and a
// whole-frame parallel load port (load wins when both are active).
module deser_word_buffer
  import nn_pkg::*;
#(
  parameter int DW = DATA_WIDTH,
  parameter int NW = 16,
  parameter int CW = $clog2(NW + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [CW-1:0]    wr_slot_i,
  input  logic [DW-1:0]    wr_data_i,
  input  logic             load_en_i,
  input  logic [DW*NW-1:0] load_frame_i,
  output logic [DW*NW-1:0] frame_o
);

  logic [DW*NW-1:0] frame_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_q <= '0;
    end else if (load_en_i) begin
      frame_q <= load_frame_i;
    end else if (wr_en_i) begin
      for (int k = 0; k < NW; k++) begin
        if (wr_slot_i == CW'(k)) frame_q[slot_msb(k, DW) -: DW] <= wr_data_i;
      end
    end
  end

  assign frame_o = frame_q;

endmodule

// File: rtl/input_deserializer.sv
// Packs a word-serial stream into one parallel frame of numWords words.
// Handshake: a word moves on a rising edge when inValid && inReady; a frame
// moves when outValid && outReady. Define DESER_DOUBLE_BUFFER_EN for a
// separate assembly buffer so a new frame can fill while the last one is held.
module input_deserializer
  import nn_pkg::*;
#(
  parameter int dataWidth    = DATA_WIDTH,
  parameter int numWords     = 16,
  parameter int counterWidth = $clog2(numWords + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [dataWidth-1:0]          inData,
  input  logic                          inValid,
  output logic                          inReady,
  output logic [dataWidth*numWords-1:0] outData,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [counterWidth-1:0]       wordCount,
  output logic [1:0]                    dbgState
);

  deser_state_t            state_q, state_d;
  logic [counterWidth-1:0] count_q, count_d;
  logic                    accept;
  logic                    last_slot;

  assign inReady   = (state_q == ST_FILL);
  assign accept    = inValid && inReady;
  assign last_slot = (count_q == counterWidth'(numWords - 1));
  assign wordCount = count_q;
  assign dbgState  = state_q;

`ifdef DESER_DOUBLE_BUFFER_EN

  logic                          out_valid_q, out_valid_d;
  logic                          out_free;
  logic                          xfer;
  logic [dataWidth*numWords-1:0] asm_frame;
  logic [dataWidth*numWords-1:0] merged_frame;
  logic [dataWidth*numWords-1:0] xfer_frame;

  assign out_free = !out_valid_q || outReady;
  assign outValid = out_valid_q;

  // The last word is still on inData when the frame transfers, so splice it in.
  always_comb begin
    merged_frame = asm_frame;
    merged_frame[slot_msb(numWords - 1, dataWidth) -: dataWidth] = inData;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    xfer        = 1'b0;
    xfer_frame  = asm_frame;
    if (flush) begin
      state_d     = ST_FILL;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (out_valid_q && outReady) out_valid_d = 1'b0;
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (last_slot) begin
              count_d = '0;
              if (out_free) begin
                xfer        = 1'b1;
                xfer_frame  = merged_frame;
                out_valid_d = 1'b1;
              end else begin
                state_d = ST_FULL_WAIT;
              end
            end else begin
              count_d = count_q + counterWidth'(1);
            end
          end
        end
        ST_FULL_WAIT: begin
          if (out_free) begin
            xfer        = 1'b1;
            out_valid_d = 1'b1;
            state_d     = ST_FILL;
          end
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_FILL;
      count_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
    end
  end

  deser_word_buffer #(.DW(dataWidth), .NW(numWords), .CW(counterWidth)) u_asm_buf (
    .clk          (clk),
    .rst          (reset),
    .wr_en_i      (accept && !flush),
    .wr_slot_i    (count_q),
    .wr_data_i    (inData),
    .load_en_i    (1'b0),
    .load_frame_i ('0),
    .frame_o      (asm_frame)
  );

  deser_word_buffer #(.DW(dataWidth), .NW(numWords), .CW(counterWidth)) u_out_buf (
    .clk          (clk),
    .rst          (reset),
    .wr_en_i      (1'b0),
    .wr_slot_i    ('0),
    .wr_data_i    ('0),
    .load_en_i    (xfer),
    .load_frame_i (xfer_frame),
    .frame_o      (outData)
  );

`else

  assign outValid = (state_q == ST_HOLD);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    if (flush) begin
      state_d = ST_FILL;
      count_d = '0;
    end else begin
      case (state_q)
        ST_FILL: begin
          if (accept) begin
            if (last_slot) begin
              count_d = '0;
              state_d = ST_HOLD;
            end else begin
              count_d = count_q + counterWidth'(1);
            end
          end
        end
        ST_HOLD: begin
          if (outReady) state_d = ST_FILL;
        end
        default: state_d = ST_FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // A flushed beat is dropped, so it must not reach the buffer either.
  deser_word_buffer #(.DW(dataWidth), .NW(numWords), .CW(counterWidth)) u_buf (
    .clk          (clk),
    .rst          (reset),
    .wr_en_i      (accept && !flush),
    .wr_slot_i    (count_q),
    .wr_data_i    (inData),
    .load_en_i    (1'b0),
    .load_frame_i ('0),
    .frame_o      (outData)
  );

`endif

endmodule
